// File: rtl/pcm_pkg.sv
// Shared types and constants for the PCM stream player.
package pcm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFetch,
    StPresent
  } pcm_state_e;

  localparam logic [2:0] RegCtrl    = 3'd0;
  localparam logic [2:0] RegRateSel = 3'd1;
  localparam logic [2:0] RegTblIdx  = 3'd2;
  localparam logic [2:0] RegTblVal  = 3'd3;
  localparam logic [2:0] RegEndLo   = 3'd4;
  localparam logic [2:0] RegEndHi   = 3'd5;
  localparam logic [2:0] RegVol     = 3'd6;

  localparam int unsigned CtrlPlay  = 0;
  localparam int unsigned CtrlPause = 1;
  localparam int unsigned CtrlLoop  = 2;
  localparam int unsigned CtrlStop  = 3;

  localparam int unsigned DefaultInterval = 6250;

endpackage

// File: rtl/pcm_stream_player_if.sv
// Control bus, sample ROM port and streaming outputs of the PCM stream player.
interface pcm_stream_player_if #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned NUM_CH   = 2
);
  logic                         chipselect;
  logic                         write;
  logic                         read;
  logic [2:0]                   address;
  logic [15:0]                  writedata;
  logic [15:0]                  readdata;
  logic [ADDR_W-1:0]            rom_addr;
  logic [SAMPLE_W-1:0]          rom_data;
  logic [NUM_CH-1:0]            st_ready;
  logic [NUM_CH-1:0]            st_valid;
  logic [NUM_CH*SAMPLE_W-1:0]   st_data;
  logic                         done;

  modport master (
    output chipselect, write, read, address, writedata, rom_data, st_ready,
    input  readdata, rom_addr, st_valid, st_data, done
  );

  modport slave (
    input  chipselect, write, read, address, writedata, rom_data, st_ready,
    output readdata, rom_addr, st_valid, st_data, done
  );
endinterface

// File: rtl/pcm_rate_divider.sv
// Sample-rate divider: counts while enabled and not paused, ticks when count reaches limit.
module pcm_rate_divider #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pause,
  input  logic             clear,
  input  logic [DIV_W-1:0] limit,
  output logic             tick
);
  logic [DIV_W-1:0] count_q;

  assign tick = enable && !pause && !clear && (count_q >= limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear || tick) begin
      count_q <= '0;
    end else if (enable && !pause) begin
      count_q <= count_q + 1'b1;
    end
  end
endmodule

// File: rtl/pcm_stream_player.sv
// PCM playback engine: paces ROM fetches with a rate table and fans each sample out
// to NUM_CH ready/valid lanes. Assumes 16 < ADDR_W and DIV_W <= 16.
module pcm_stream_player
  import pcm_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned NUM_RATES = 4
) (
  input logic                clk,
  input logic                reset,
  pcm_stream_player_if.slave bus
);
  localparam int unsigned RATE_W = $clog2(NUM_RATES);

  pcm_state_e          state_q, state_d;
  logic [DIV_W-1:0]    interval_q [NUM_RATES];
  logic [RATE_W-1:0]   rate_sel_q, tbl_idx_q;
  logic [ADDR_W-1:0]   end_q, addr_q, addr_d;
  logic [3:0]          vol_q;
  logic                loop_q, paused_q;
  logic [7:0]          overrun_q;
  logic [NUM_CH-1:0]   valid_q, valid_d;
  logic [SAMPLE_W-1:0] sample_q;
  logic                done_q, done_d;
  logic [15:0]         readdata_q;
  logic                wr, play, stop, tick, busy;

  assign wr   = bus.chipselect && bus.write;
  assign play = wr && (bus.address == RegCtrl) && bus.writedata[CtrlPlay];
  assign stop = wr && (bus.address == RegCtrl) && bus.writedata[CtrlStop];
  assign busy = (state_q != StIdle);

  pcm_rate_divider #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .enable(busy),
    .pause (paused_q),
    .clear (!busy || stop),
    .limit (interval_q[rate_sel_q]),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RATES; i++) interval_q[i] <= DIV_W'(DefaultInterval);
      rate_sel_q <= '0;
      tbl_idx_q  <= '0;
      end_q      <= '1;
      vol_q      <= '0;
      loop_q     <= 1'b0;
      paused_q   <= 1'b0;
    end else if (wr) begin
      case (bus.address)
        RegCtrl: begin
          paused_q <= bus.writedata[CtrlPause];
          loop_q   <= bus.writedata[CtrlLoop];
        end
        RegRateSel: rate_sel_q <= bus.writedata[RATE_W-1:0];
        RegTblIdx:  tbl_idx_q <= bus.writedata[RATE_W-1:0];
        RegTblVal:  interval_q[tbl_idx_q] <= bus.writedata[DIV_W-1:0];
        RegEndLo:   end_q[15:0] <= bus.writedata;
        RegEndHi:   end_q[ADDR_W-1:16] <= bus.writedata[ADDR_W-17:0];
        RegVol:     vol_q <= bus.writedata[3:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        addr_d = '0;
        if (play) state_d = StRun;
      end
      StRun: begin
        if (tick) state_d = StFetch;
      end
      StFetch: begin
        valid_d = '1;
        state_d = StPresent;
      end
      StPresent: begin
        valid_d = valid_q & ~bus.st_ready;
        // Advance only once every lane has taken the sample.
        if (valid_d == '0) begin
          if (addr_q == end_q) begin
            addr_d = '0;
            if (loop_q) begin
              state_d = StRun;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StRun;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (stop) begin
      state_d = StIdle;
      valid_d = '0;
      addr_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      valid_q    <= '0;
      sample_q   <= '0;
      done_q     <= 1'b0;
      overrun_q  <= '0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (state_q == StFetch) sample_q <= $signed(bus.rom_data) >>> vol_q;
      // A tick while a sample is still in flight is lost and counted.
      if (stop) begin
        overrun_q <= '0;
      end else if (tick && (state_q == StFetch || state_q == StPresent) &&
                   overrun_q != 8'hFF) begin
        overrun_q <= overrun_q + 1'b1;
      end
      if (bus.chipselect && bus.read) begin
        readdata_q <= {overrun_q, 4'b0, loop_q, paused_q, busy, busy && !paused_q};
      end
    end
  end

  assign bus.st_valid = valid_q;
  assign bus.st_data  = {NUM_CH{sample_q}};
  assign bus.rom_addr = addr_q;
  assign bus.done     = done_q;
  assign bus.readdata = readdata_q;
endmodule

// File: tb/tb_pcm_stream_player.sv
// Bench for pcm_stream_player: per-cycle comparison against a behavioural playback model.
module tb_pcm_stream_player;
  localparam int unsigned SW = 16;
  localparam int unsigned AW = 17;
  localparam int unsigned NC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pcm_stream_player_if #(.SAMPLE_W(SW), .ADDR_W(AW), .NUM_CH(NC)) bus ();

  pcm_stream_player #(
    .SAMPLE_W (SW),
    .ADDR_W   (AW),
    .NUM_CH   (NC),
    .DIV_W    (16),
    .NUM_RATES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] rom [64];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr[5:0]];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model of the player as seen from outside: playing or not, where the current sample is
  // in its life (0 waiting for tick, 1 being fetched, 2 offered to the lanes).
  bit          m_busy, m_paused, m_loop, m_done;
  int          m_phase, m_cnt, m_ovr, m_addr, m_end, m_vol, m_sel, m_idx;
  int          m_int [4];
  logic [1:0]  m_valid;
  logic [15:0] m_sample, m_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] attn(input logic [15:0] s, input int sh);
    logic signed [15:0] x;
    x = s;
    return 16'(x >>> sh);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_paused = 0; m_loop = 0; m_done = 0;
    m_phase = 0; m_cnt = 0; m_ovr = 0; m_addr = 0; m_end = (1 << AW) - 1;
    m_vol = 0; m_sel = 0; m_idx = 0;
    for (int i = 0; i < 4; i++) m_int[i] = 6250;
    m_valid = '0; m_sample = '0; m_rd = '0;
  endtask

  task automatic compare();
    chk("st_valid", 64'(bus.st_valid), 64'(m_valid));
    chk("rom_addr", 64'(bus.rom_addr), 64'(m_addr));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("readdata", 64'(bus.readdata), 64'(m_rd));
    for (int k = 0; k < NC; k++)
      if (m_valid[k]) chk("st_data", 64'(bus.st_data[k*SW +: SW]), 64'(m_sample));
  endtask

  // Advance the model by one clock given the inputs presented for that clock.
  task automatic advance();
    bit wr, play, stop, tick;
    int a;
    logic [15:0] wd;
    logic [1:0] rdy;
    wr = bus.chipselect && bus.write;
    a = int'(bus.address);
    wd = bus.writedata;
    rdy = bus.st_ready;
    play = wr && a == 0 && wd[0];
    stop = wr && a == 0 && wd[3];
    if (bus.chipselect && bus.read)
      m_rd = {8'(m_ovr), 4'b0, m_loop, m_paused, m_busy, m_busy && !m_paused};
    m_done = 0;
    // Ticks come every interval+1 unpaused playing cycles.
    tick = m_busy && !m_paused && (m_cnt >= m_int[m_sel]);
    if (!m_busy || tick) m_cnt = 0;
    else if (!m_paused) m_cnt++;
    if (tick && m_phase != 0) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
    if (m_busy) begin
      if (m_phase == 0) begin
        if (tick) m_phase = 1;
      end else if (m_phase == 1) begin
        m_sample = attn(rom[m_addr % 64], m_vol);
        m_valid = '1;
        m_phase = 2;
      end else begin
        m_valid = m_valid & ~rdy;
        if (m_valid == 0) begin
          m_phase = 0;
          if (m_addr == m_end) begin
            m_addr = 0;
            if (!m_loop) begin
              m_busy = 0;
              m_done = 1;
            end
          end else begin
            m_addr = (m_addr + 1) % (1 << AW);
          end
        end
      end
    end else if (play) begin
      m_busy = 1;
      m_phase = 0;
    end
    if (stop) begin
      m_busy = 0; m_phase = 0; m_valid = '0; m_addr = 0; m_ovr = 0; m_done = 0;
    end
    if (wr) begin
      case (a)
        0: begin m_paused = wd[1]; m_loop = wd[2]; end
        1: m_sel = int'(wd[1:0]);
        2: m_idx = int'(wd[1:0]);
        3: m_int[m_idx] = int'(wd);
        4: m_end = (m_end & ~32'hFFFF) | int'(wd);
        5: m_end = (m_end & 32'hFFFF) | (int'(wd[0]) << 16);
        6: m_vol = int'(wd[3:0]);
        default: ;
      endcase
    end
  endtask

  task automatic step();
    compare();
    advance();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    step();
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd_reg(output logic [15:0] v);
    bus.chipselect = 1'b1; bus.read = 1'b1;
    step();
    bus.chipselect = 1'b0; bus.read = 1'b0;
    v = bus.readdata;
  endtask

  initial begin
    int n, nd, last, t, v1, v2, w, u, nv, r;
    logic [15:0] v, d1;
    logic lp, pz;

    bus.chipselect = 0; bus.write = 0; bus.read = 0; bus.address = '0;
    bus.writedata = '0; bus.st_ready = '0;
    for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h8000;
    rom[1] = 16'h0010;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(bus.st_valid), 64'd0);
    chk("rst_data", 64'(bus.st_data), 64'd0);
    chk("rst_addr", 64'(bus.rom_addr), 64'd0);
    chk("rst_readdata", 64'(bus.readdata), 64'd0);
    reset = 1'b0;

    // One-shot, END=3, interval 4: four samples spaced 5 cycles, one done pulse.
    bus.st_ready = 2'b11;
    wr_reg(3'd4, 16'd3); wr_reg(3'd5, 16'd0); wr_reg(3'd2, 16'd0); wr_reg(3'd3, 16'd4);
    wr_reg(3'd0, 16'h0001);
    n = 0; nd = 0; last = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.st_valid[0] && bus.st_ready[0]) begin
        if (n < 4) chk("t1_sample", 64'(bus.st_data[15:0]), 64'(rom[n]));
        if (n > 0) chk("t1_gap", 64'(cyc - last), 64'd5);
        last = cyc;
        n++;
      end
      if (bus.done) nd++;
      step();
    end
    chk("t1_count", 64'(n), 64'd4);
    chk("t1_done_pulses", 64'(nd), 64'd1);
    rd_reg(v);
    chk("t1_busy", 64'(v[1]), 64'd0);

    // Attenuation by 2: sign-extending shift.
    wr_reg(3'd6, 16'd2); wr_reg(3'd4, 16'd1); wr_reg(3'd0, 16'h0001);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.st_valid[0] && bus.st_ready[0]) begin
        if (n == 0) chk("vol_neg", 64'(bus.st_data[15:0]), 64'h0000_0000_0000_E000);
        if (n == 1) chk("vol_pos", 64'(bus.st_data[31:16]), 64'h0000_0000_0000_0004);
        n++;
      end
      step();
    end
    chk("vol_count", 64'(n), 64'd2);
    wr_reg(3'd6, 16'd0);

    // Loop over END=1: alternating samples, never done.
    wr_reg(3'd0, 16'h0005);
    n = 0; nd = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.st_valid[0] && bus.st_ready[0]) begin
        chk("loop_sample", 64'(bus.st_data[15:0]), 64'(rom[n % 2]));
        n++;
      end
      if (bus.done) nd++;
      step();
    end
    chk("loop_many", 64'(n >= 8), 64'd1);
    chk("loop_no_done", 64'(nd), 64'd0);
    wr_reg(3'd0, 16'h0008);

    // Lane 1 stalls 10 cycles: lane 0 drops, lane 1 holds, two overruns.
    bus.st_ready = 2'b01;
    wr_reg(3'd0, 16'h0001);
    t = 0;
    while (!bus.st_valid[1] && t < 100) begin step(); t++; end
    chk("t3_valid_both", 64'(bus.st_valid), 64'd3);
    d1 = bus.st_data[31:16];
    chk("t3_data", 64'(d1), 64'h0000_0000_0000_8000);
    step();
    chk("t3_lane0_drop", 64'(bus.st_valid), 64'd2);
    repeat (9) step();
    chk("t3_lane1_held", 64'(bus.st_valid), 64'd2);
    chk("t3_data_held", 64'(bus.st_data[31:16]), 64'(d1));
    chk("t3_addr_wait", 64'(bus.rom_addr), 64'd0);
    bus.st_ready = 2'b11;
    step();
    chk("t3_addr_adv", 64'(bus.rom_addr), 64'd1);
    rd_reg(v);
    chk("t3_overrun", 64'(v[15:8]), 64'd2);
    repeat (20) step();
    wr_reg(3'd0, 16'h0008);

    // Pause mid-run: divider frozen, resumes with the remaining interval.
    wr_reg(3'd2, 16'd1); wr_reg(3'd3, 16'd20); wr_reg(3'd1, 16'd1); wr_reg(3'd4, 16'd63);
    wr_reg(3'd0, 16'h0001);
    t = 0;
    while (!bus.st_valid[0] && t < 100) begin step(); t++; end
    v1 = cyc;
    repeat (5) step();
    w = cyc;
    wr_reg(3'd0, 16'h0002);
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.st_valid != 0) nv++;
      step();
    end
    chk("pause_no_valid", 64'(nv), 64'd0);
    rd_reg(v);
    chk("pause_status", 64'(v[1:0]), 64'd2);
    u = cyc;
    wr_reg(3'd0, 16'h0000);
    t = 0;
    while (!bus.st_valid[0] && t < 200) begin step(); t++; end
    v2 = cyc;
    chk("pause_gap", 64'(v2 - v1), 64'(21 + (u - w)));

    // Stop while a sample is held: valid and address clear at once.
    bus.st_ready = 2'b00;
    repeat (2) step();
    chk("stop_pre_valid", 64'(bus.st_valid), 64'd3);
    wr_reg(3'd0, 16'h0008);
    chk("stop_valid", 64'(bus.st_valid), 64'd0);
    chk("stop_addr", 64'(bus.rom_addr), 64'd0);
    rd_reg(v);
    chk("stop_idle", 64'(v[1:0]), 64'd0);

    // Asynchronous reset mid-present.
    wr_reg(3'd0, 16'h0001);
    t = 0;
    while (!bus.st_valid[0] && t < 100) begin step(); t++; end
    step();
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.st_valid), 64'd0);
    chk("arst_data", 64'(bus.st_data), 64'd0);
    chk("arst_addr", 64'(bus.rom_addr), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_readdata", 64'(bus.readdata), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomised runs: short intervals (including 0), random ready, pause and stray plays.
    for (int it = 0; it < 25; it++) begin
      wr_reg(3'd0, 16'h0008);
      for (int j = 0; j < 4; j++) begin
        wr_reg(3'd2, 16'(j));
        wr_reg(3'd3, 16'($urandom_range(0, 6)));
      end
      wr_reg(3'd1, 16'($urandom_range(0, 3)));
      wr_reg(3'd4, 16'($urandom_range(0, 5)));
      wr_reg(3'd6, 16'($urandom_range(0, 15)));
      lp = 1'($urandom);
      pz = 1'b0;
      wr_reg(3'd0, {12'b0, 1'b0, lp, 1'b0, 1'b1});
      for (int c = 0; c < 120; c++) begin
        bus.st_ready = 2'($urandom);
        r = $urandom_range(0, 49);
        if (r == 0) begin
          pz = !pz;
          wr_reg(3'd0, {12'b0, 1'b0, lp, pz, 1'b0});
        end else if (r == 1) begin
          wr_reg(3'd0, {12'b0, 1'b0, lp, pz, 1'b1});
        end else if (r == 2) begin
          rd_reg(v);
        end else begin
          step();
        end
      end
      rd_reg(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
